branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1: the ID stage holds a valid instruction.
REQ-004 SHALL have port id_is_branch, input, 1: the ID instruction is a branch or jump.
REQ-005 SHALL have port id_br_cond, input, 3: condition code (EQ, NE, LTZ, GEZ, GTZ, LEZ, JUMP, JREG).
REQ-006 SHALL have port id_pc, input, 32: PC of the branch instruction.
REQ-007 SHALL have port id_instr, input, 32: raw instruction word; offset in [15:0], index in [25:0].
REQ-008 SHALL have ports id_rs_addr and id_rt_addr, input, 5 each, and id_rs_val and id_rt_val, input, 32 each: operand addresses and forwarded operand values.
REQ-009 SHALL have ports ex_wen, input, 1, and ex_waddr, input, 5: the EX-stage writeback target.
REQ-010 SHALL have ports mem_wen, mem_is_load and mem_data_ok, input, 1 each, and mem_waddr, input, 5: MEM-stage writeback and load status.
REQ-011 SHALL have port flush, input, 1: exception or ERET pipeline flush.
REQ-012 SHALL have port if_redirect_ack, input, 1: IF accepts the redirect.
REQ-013 SHALL have port id_stall, output, 1: hold the ID stage; combinational.
REQ-014 SHALL have port br_redirect_valid, output, 1: a redirect is pending; registered.
REQ-015 SHALL have port br_target, output, 32: the redirect PC; registered.

Function
REQ-016 SHALL implement the states IDLE, WAIT_OPND and REDIRECT.
REQ-017 SHALL treat operand usage as follows: EQ/NE use rs and rt; LTZ/GEZ/GTZ/LEZ/JREG use rs only; JUMP uses no operands.
REQ-018 SHALL detect a hazard when a used operand has a nonzero address that matches either (a) ex_waddr with ex_wen=1, or (b) mem_waddr with mem_wen=1, mem_is_load=1 and mem_data_ok=0; register 0 never causes a hazard.
REQ-019 In IDLE or WAIT_OPND with id_valid and id_is_branch set, SHALL stall on a hazard and go to WAIT_OPND; otherwise SHALL resolve the branch in that cycle with id_stall=0.
REQ-020 SHALL evaluate the conditions as: EQ rs==rt; NE rs!=rt; LTZ/GEZ/GTZ/LEZ as a signed compare of rs with 0; JUMP and JREG always taken.
REQ-021 SHALL compute the target as follows: conditional = id_pc+4+(sign-extended offset<<2), modulo 2^32; JUMP = {(id_pc+4)[31:28], index, 2'b00}; JREG = rs value unmodified.
REQ-022 On a taken resolve, SHALL register br_target and set br_redirect_valid=1 in the next cycle, with state REDIRECT.
REQ-023 On a not-taken resolve, SHALL leave the state at IDLE and generate no redirect.
REQ-024 In REDIRECT, br_target and br_redirect_valid SHALL be held stable until if_redirect_ack=1, after which state is IDLE and valid=0 in the next cycle.
REQ-025 In REDIRECT, SHALL assert id_stall for any branch in ID; non-branch instructions (the delay slot) SHALL pass unstalled.
REQ-026 When if_redirect_ack and a new ID branch coincide, SHALL still stall the new branch that cycle and evaluate it in the following cycle.
REQ-027 When id_valid or id_is_branch drops while in WAIT_OPND, SHALL return to IDLE without a redirect.
REQ-028 SHALL give flush highest priority: state IDLE and br_redirect_valid=0 next cycle, id_stall=0 in the flush cycle, and any pending redirect or ack is discarded.

Reset
REQ-029 While resetn=0 at a clock edge, SHALL set state=IDLE, br_redirect_valid=0 and br_target=32'h0; id_stall SHALL be 0 during reset.
REQ-030 SHALL let reset asserted mid-REDIRECT or mid-WAIT_OPND abandon the operation with no redirect issued afterward.

Structure
REQ-031 SHALL place the condition-code encodings, the state encoding and the operand-usage decode constants in shared package branch_pkg.
REQ-032 SHALL instantiate exactly one combinational sub-module, br_cond_unit, that takes cond, rs and rt and returns taken; all sequencing stays in branch_resolve_ctrl.

Verification
REQ-033 SHALL cover BEQ with rs=rt=5, pc=0x1000, offset=0x0004 -> no stall, redirect_valid next cycle, target=0x1014, held until ack.
REQ-034 SHALL cover BNE rs=3 while ex_wen=1 and ex_waddr=3 for 2 cycles -> id_stall=1 for 2 cycles, state WAIT_OPND, then resolve with no redirect when the values are equal.
REQ-035 SHALL cover BLTZ with rs=0x80000000 -> taken, and BGTZ with rs=0 -> not taken (signed-boundary check).
REQ-036 SHALL cover JR with rs=0xBFC00380 and ack withheld 3 cycles -> target stable all 3 cycles, and a second branch in ID stalls until the cycle after ack.
REQ-037 SHALL cover flush asserted in the first REDIRECT cycle -> redirect_valid=0 next cycle, state IDLE, and a later ack is ignored.
REQ-038 SHALL cover a load in MEM to rs with mem_data_ok=0 for 4 cycles and resetn=0 on cycle 2 -> state IDLE and outputs at their reset values, with no redirect.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve controller: condition codes,
// FSM states and the per-condition operand-usage decode.
package branch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned CW   = 3;
   localparam int unsigned SW   = 2;

   localparam logic [CW-1:0] COND_EQ   = 3'd0;
   localparam logic [CW-1:0] COND_NE   = 3'd1;
   localparam logic [CW-1:0] COND_LTZ  = 3'd2;
   localparam logic [CW-1:0] COND_GEZ  = 3'd3;
   localparam logic [CW-1:0] COND_GTZ  = 3'd4;
   localparam logic [CW-1:0] COND_LEZ  = 3'd5;
   localparam logic [CW-1:0] COND_JUMP = 3'd6;
   localparam logic [CW-1:0] COND_JREG = 3'd7;

   localparam logic [SW-1:0] ST_IDLE      = 2'd0;
   localparam logic [SW-1:0] ST_WAIT_OPND = 2'd1;
   localparam logic [SW-1:0] ST_REDIRECT  = 2'd2;

   // Bit n set means condition code n reads that operand.
   localparam logic [7:0] USE_RS_MASK = 8'b1011_1111;
   localparam logic [7:0] USE_RT_MASK = 8'b0000_0011;

endpackage

// File: rtl/br_cond_unit.sv
// Branch condition evaluation: purely combinational taken decision.
module br_cond_unit
   import branch_pkg::*;
(
   input  logic [CW-1:0]   cond,
   input  logic [XLEN-1:0] rs,
   input  logic [XLEN-1:0] rt,
   output logic            taken
);

   logic rs_neg;
   logic rs_zero;

   assign rs_neg  = rs[XLEN-1];
   assign rs_zero = (rs == '0);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ:   taken = (rs == rt);
         COND_NE:   taken = (rs != rt);
         COND_LTZ:  taken = rs_neg;
         COND_GEZ:  taken = !rs_neg;
         COND_GTZ:  taken = !rs_neg && !rs_zero;
         COND_LEZ:  taken = rs_neg || rs_zero;
         COND_JUMP: taken = 1'b1;
         COND_JREG: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolver: stalls on operand hazards, computes the target
// and holds a registered redirect toward IF until it is acknowledged.
module branch_resolve_ctrl
   import branch_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            id_valid,
   input  logic            id_is_branch,
   input  logic [CW-1:0]   id_br_cond,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_instr,
   input  logic [RW-1:0]   id_rs_addr,
   input  logic [RW-1:0]   id_rt_addr,
   input  logic [XLEN-1:0] id_rs_val,
   input  logic [XLEN-1:0] id_rt_val,
   input  logic            ex_wen,
   input  logic [RW-1:0]   ex_waddr,
   input  logic            mem_wen,
   input  logic            mem_is_load,
   input  logic            mem_data_ok,
   input  logic [RW-1:0]   mem_waddr,
   input  logic            flush,
   input  logic            if_redirect_ack,
   output logic            id_stall,
   output logic            br_redirect_valid,
   output logic [XLEN-1:0] br_target
);

   logic [SW-1:0]   state;
   logic [SW-1:0]   state_nxt;
   logic            valid_nxt;
   logic [XLEN-1:0] target_nxt;

   logic            branch_req;
   logic            use_rs;
   logic            use_rt;
   logic            rs_busy;
   logic            rt_busy;
   logic            hazard;
   logic            taken;
   logic            mem_load_pending;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] br_off;
   logic [XLEN-1:0] resolve_target;
   logic            unused_bits;

   assign branch_req = id_valid && id_is_branch;
   assign use_rs     = USE_RS_MASK[id_br_cond];
   assign use_rt     = USE_RT_MASK[id_br_cond];

   // A register is busy if EX will write it, or a MEM load to it has no data yet.
   assign mem_load_pending = mem_wen && mem_is_load && !mem_data_ok;
   assign rs_busy = (id_rs_addr != '0) &&
                    ((ex_wen && (ex_waddr == id_rs_addr)) ||
                     (mem_load_pending && (mem_waddr == id_rs_addr)));
   assign rt_busy = (id_rt_addr != '0) &&
                    ((ex_wen && (ex_waddr == id_rt_addr)) ||
                     (mem_load_pending && (mem_waddr == id_rt_addr)));
   assign hazard  = (use_rs && rs_busy) || (use_rt && rt_busy);

   assign pc4    = id_pc + XLEN'(4);
   assign br_off = {{(XLEN-18){id_instr[15]}}, id_instr[15:0], 2'b00};

   always_comb begin
      resolve_target = pc4 + br_off;
      if (id_br_cond == COND_JUMP)
         resolve_target = {pc4[31:28], id_instr[25:0], 2'b00};
      else if (id_br_cond == COND_JREG)
         resolve_target = id_rs_val;
   end

   assign unused_bits = ^{id_instr[31:26], pc4[27:0]};

   br_cond_unit u_cond (
      .cond  (id_br_cond),
      .rs    (id_rs_val),
      .rt    (id_rt_val),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state             <= ST_IDLE;
         br_redirect_valid <= 1'b0;
         br_target         <= '0;
      end else begin
         state             <= state_nxt;
         br_redirect_valid <= valid_nxt;
         br_target         <= target_nxt;
      end
   end

   // Next state; flush overrides everything, stall is forced low in reset.
   always_comb begin
      state_nxt  = state;
      valid_nxt  = br_redirect_valid;
      target_nxt = br_target;
      id_stall   = 1'b0;
      if (flush) begin
         state_nxt = ST_IDLE;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_WAIT_OPND: begin
               state_nxt = ST_IDLE;
               if (branch_req) begin
                  if (hazard) begin
                     id_stall  = 1'b1;
                     state_nxt = ST_WAIT_OPND;
                  end else if (taken) begin
                     state_nxt  = ST_REDIRECT;
                     valid_nxt  = 1'b1;
                     target_nxt = resolve_target;
                  end
               end
            end
            ST_REDIRECT: begin
               id_stall = branch_req;
               if (if_redirect_ack) begin
                  state_nxt = ST_IDLE;
                  valid_nxt = 1'b0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               valid_nxt = 1'b0;
            end
         endcase
      end
      if (!resetn)
         id_stall = 1'b0;
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        id_valid, id_is_branch;
   logic [2:0]  id_br_cond;
   logic [31:0] id_pc, id_instr, id_rs_val, id_rt_val;
   logic [4:0]  id_rs_addr, id_rt_addr, ex_waddr, mem_waddr;
   logic        ex_wen, mem_wen, mem_is_load, mem_data_ok;
   logic        flush, if_redirect_ack;
   logic        id_stall, br_redirect_valid;
   logic [31:0] br_target;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_is_branch(id_is_branch),
      .id_br_cond(id_br_cond), .id_pc(id_pc), .id_instr(id_instr),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .ex_wen(ex_wen), .ex_waddr(ex_waddr),
      .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_data_ok(mem_data_ok),
      .mem_waddr(mem_waddr), .flush(flush), .if_redirect_ack(if_redirect_ack),
      .id_stall(id_stall), .br_redirect_valid(br_redirect_valid), .br_target(br_target)
   );

   // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_is_branch = 0; id_br_cond = COND_EQ;
      id_pc = 0; id_instr = 0; id_rs_addr = 0; id_rt_addr = 0;
      id_rs_val = 0; id_rt_val = 0; ex_wen = 0; ex_waddr = 0;
      mem_wen = 0; mem_is_load = 0; mem_data_ok = 1; mem_waddr = 0;
      flush = 0; if_redirect_ack = 0;
   endtask

   task automatic set_branch(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [4:0] ra, input logic [31:0] rv,
                             input logic [4:0] ta, input logic [31:0] tv);
      id_valid = 1; id_is_branch = 1; id_br_cond = c; id_pc = pc; id_instr = ins;
      id_rs_addr = ra; id_rs_val = rv; id_rt_addr = ta; id_rt_val = tv;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 0;
      set_branch(COND_EQ, 32'h100, 32'h1, 5'd3, 0, 5'd3, 0);
      ex_wen = 1; ex_waddr = 5'd3;
      tick();
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", id_stall); end
      tick();
      n_cmp++; if (br_redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", br_redirect_valid); end
      n_cmp++; if (br_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h want 0", br_target); end
      n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE); end
      idle_inputs();
      resetn = 1;
      tick();
   endtask

   task automatic test_beq_taken();
      set_branch(COND_EQ, 32'h1000, 32'h1022_0004, 5'd1, 32'd5, 5'd2, 32'd5);
      #1;
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL beq_stall: got %b want 0", id_stall); end
      tick();
      idle_inputs();
      id_valid = 1;
      #1;
      n_cmp++; if (br_redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid: got %b want 1", br_redirect_valid); end
      n_cmp++; if (br_target !== 32'h1014) begin n_err++; $display("FAIL beq_target: got %h want 00001014", br_target); end
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL beq_delay_slot_stall: got %b want 0", id_stall); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'h1014) begin
            n_err++; $display("FAIL beq_hold%0d: got %b/%h want 1/00001014", i, br_redirect_valid, br_target); end
      end
      if_redirect_ack = 1;
      tick();
      if_redirect_ack = 0;
      n_cmp++; if (br_redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_ack_valid: got %b want 0", br_redirect_valid); end
      n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL beq_ack_state: got %0d want %0d", dut.state, ST_IDLE); end
      idle_inputs();
   endtask

   task automatic test_bne_hazard();
      set_branch(COND_NE, 32'h2000, 32'h1443_0008, 5'd3, 32'd7, 5'd4, 32'd7);
      ex_wen = 1; ex_waddr = 5'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL bne_stall%0d: got %b want 1", i, id_stall); end
         tick();
         n_cmp++; if (dut.state !== ST_WAIT_OPND) begin n_err++; $display("FAIL bne_state%0d: got %0d want %0d", i, dut.state, ST_WAIT_OPND); end
      end
      ex_wen = 0;
      #1;
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL bne_release: got %b want 0", id_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b0) begin n_err++; $display("FAIL bne_no_redirect: got %b want 0", br_redirect_valid); end
      n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL bne_end_state: got %0d want %0d", dut.state, ST_IDLE); end
      // r0 as a write target never blocks a branch
      set_branch(COND_NE, 32'h2100, 32'h0000_0002, 5'd0, 32'd0, 5'd6, 32'd1);
      ex_wen = 1; ex_waddr = 5'd0;
      #1;
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", id_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'h210C) begin
         n_err++; $display("FAIL r0_redirect: got %b/%h want 1/0000210c", br_redirect_valid, br_target); end
      if_redirect_ack = 1;
      tick();
      idle_inputs();
   endtask

   task automatic test_signed_and_jump();
      set_branch(COND_LTZ, 32'h2000, 32'h0400_FFFC, 5'd9, 32'h8000_0000, 5'd0, 0);
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'h1FF4) begin
         n_err++; $display("FAIL bltz: got %b/%h want 1/00001ff4", br_redirect_valid, br_target); end
      if_redirect_ack = 1;
      tick();
      idle_inputs();
      set_branch(COND_GTZ, 32'h2200, 32'h1C00_0010, 5'd9, 32'h0, 5'd0, 0);
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b0 || dut.state !== ST_IDLE) begin
         n_err++; $display("FAIL bgtz_zero: got %b/%0d want 0/%0d", br_redirect_valid, dut.state, ST_IDLE); end
      set_branch(COND_JUMP, 32'hA000_0010, 32'h0812_3456, 5'd0, 0, 5'd0, 0);
      ex_wen = 1; ex_waddr = 5'd5;
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'hA048_D158) begin
         n_err++; $display("FAIL jump: got %b/%h want 1/a048d158", br_redirect_valid, br_target); end
      if_redirect_ack = 1;
      tick();
      idle_inputs();
   endtask

   task automatic test_jr_back_to_back();
      set_branch(COND_JREG, 32'h4000, 32'h03E0_0008, 5'd31, 32'hBFC0_0380, 5'd0, 0);
      tick();
      set_branch(COND_EQ, 32'h3000, 32'h1000_0001, 5'd1, 32'd9, 5'd2, 32'd9);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'hBFC0_0380 || id_stall !== 1'b1) begin
            n_err++; $display("FAIL jr_hold%0d: got v=%b t=%h s=%b want 1/bfc00380/1", i, br_redirect_valid, br_target, id_stall); end
         tick();
      end
      if_redirect_ack = 1;
      #1;
      n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL jr_ack_stall: got %b want 1", id_stall); end
      tick();
      if_redirect_ack = 0;
      n_cmp++; if (br_redirect_valid !== 1'b0 || dut.state !== ST_IDLE) begin
         n_err++; $display("FAIL jr_after_ack: got %b/%0d want 0/%0d", br_redirect_valid, dut.state, ST_IDLE); end
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL jr_second_stall: got %b want 0", id_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b1 || br_target !== 32'h3008) begin
         n_err++; $display("FAIL jr_second_target: got %b/%h want 1/00003008", br_redirect_valid, br_target); end
      if_redirect_ack = 1;
      tick();
      idle_inputs();
   endtask

   task automatic test_flush();
      set_branch(COND_EQ, 32'h1000, 32'h1022_0004, 5'd1, 32'd5, 5'd2, 32'd5);
      tick();
      flush = 1;
      #1;
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", id_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b0 || dut.state !== ST_IDLE) begin
         n_err++; $display("FAIL flush_cancel: got %b/%0d want 0/%0d", br_redirect_valid, dut.state, ST_IDLE); end
      if_redirect_ack = 1;
      tick();
      idle_inputs();
      n_cmp++; if (br_redirect_valid !== 1'b0 || dut.state !== ST_IDLE) begin
         n_err++; $display("FAIL flush_late_ack: got %b/%0d want 0/%0d", br_redirect_valid, dut.state, ST_IDLE); end
   endtask

   task automatic test_load_reset();
      set_branch(COND_LTZ, 32'h5000, 32'h0500_0010, 5'd8, 32'h8000_0000, 5'd0, 0);
      mem_wen = 1; mem_is_load = 1; mem_data_ok = 0; mem_waddr = 5'd8;
      #1;
      n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL load_stall: got %b want 1", id_stall); end
      tick();
      n_cmp++; if (dut.state !== ST_WAIT_OPND) begin n_err++; $display("FAIL load_wait: got %0d want %0d", dut.state, ST_WAIT_OPND); end
      resetn = 0;
      #1;
      n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL load_reset_stall: got %b want 0", id_stall); end
      tick();
      resetn = 1;
      n_cmp++; if (dut.state !== ST_IDLE || br_redirect_valid !== 1'b0 || br_target !== 32'h0) begin
         n_err++; $display("FAIL load_reset_state: got %0d/%b/%h want %0d/0/0", dut.state, br_redirect_valid, br_target, ST_IDLE); end
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL load_restall%0d: got %b want 1", i, id_stall); end
         tick();
      end
      id_valid = 0;
      tick();
      idle_inputs();
      n_cmp++; if (dut.state !== ST_IDLE || br_redirect_valid !== 1'b0) begin
         n_err++; $display("FAIL load_abandon: got %0d/%b want %0d/0", dut.state, br_redirect_valid, ST_IDLE); end
      tick();
      n_cmp++; if (br_redirect_valid !== 1'b0) begin n_err++; $display("FAIL load_no_redirect: got %b want 0", br_redirect_valid); end
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_bne_hazard();
      test_signed_and_jump();
      test_jr_back_to_back();
      test_flush();
      test_load_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
